bp_mc_direct_access_bridge: RTL



---
 rtl/bp_mc_link_pkg.sv | 92 +++++++++
 rtl/bp_mc_direct_access_bridge.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_mc_link_pkg.sv
// Shared types and constants for the BP-to-manycore mailbox link: BedRock-style
// I/O message, host request/response packets, mailbox offsets and bridge states.
package bp_mc_link_pkg;

    localparam int paddr_width_gp = 48;
    localparam int word_width_gp  = 64;

    localparam logic [3:0] e_bedrock_mem_rd    = 4'd0;
    localparam logic [3:0] e_bedrock_mem_wr    = 4'd1;
    localparam logic [3:0] e_bedrock_mem_uc_rd = 4'd2;
    localparam logic [3:0] e_bedrock_mem_uc_wr = 4'd3;

    localparam logic [2:0] e_bedrock_msg_size_1 = 3'd0;
    localparam logic [2:0] e_bedrock_msg_size_2 = 3'd1;
    localparam logic [2:0] e_bedrock_msg_size_4 = 3'd2;
    localparam logic [2:0] e_bedrock_msg_size_8 = 3'd3;

    localparam logic [7:0] e_remote_load  = 8'd0;
    localparam logic [7:0] e_remote_store = 8'd1;

    localparam logic [paddr_width_gp-1:0] mbox_req_fifo_gp     = 48'h1000;
    localparam logic [paddr_width_gp-1:0] mbox_credits_gp      = 48'h2000;
    localparam logic [paddr_width_gp-1:0] mbox_resp_fifo_gp    = 48'h3000;
    localparam logic [paddr_width_gp-1:0] mbox_resp_entries_gp = 48'h4000;

    typedef struct packed {
        logic [word_width_gp-1:0]  data;
        logic [paddr_width_gp-1:0] addr;
        logic [2:0]                size;
        logic [3:0]                msg_type;
    } bp_io_msg_s;

    localparam int cce_mem_msg_width_gp = $bits(bp_io_msg_s);

    // Low 64-bit word is the first one written into the request FIFO.
    typedef struct packed {
        logic [15:0] pad;
        logic [31:0] addr;
        logic [7:0]  op;
        logic [7:0]  reg_id;
        logic [31:0] payload;
        logic [7:0]  y_src;
        logic [7:0]  x_src;
        logic [7:0]  y_dst;
        logic [7:0]  x_dst;
    } host_request_packet_s;

    typedef struct packed {
        logic [63:0] hi_rsvd;
        logic [7:0]  pad_hi;
        logic [31:0] data;
        logic [7:0]  reg_id;
        logic [15:0] pad_lo;
    } host_response_packet_s;

    typedef logic [3:0] bridge_state_t;

    localparam bridge_state_t S_READY        = 4'd0;
    localparam bridge_state_t S_CRED_CMD     = 4'd1;
    localparam bridge_state_t S_CRED_WAIT    = 4'd2;
    localparam bridge_state_t S_SEND_LO_CMD  = 4'd3;
    localparam bridge_state_t S_SEND_LO_WAIT = 4'd4;
    localparam bridge_state_t S_SEND_HI_CMD  = 4'd5;
    localparam bridge_state_t S_SEND_HI_WAIT = 4'd6;
    localparam bridge_state_t S_ENT_CMD      = 4'd7;
    localparam bridge_state_t S_ENT_WAIT     = 4'd8;
    localparam bridge_state_t S_RD_LO_CMD    = 4'd9;
    localparam bridge_state_t S_RD_LO_WAIT   = 4'd10;
    localparam bridge_state_t S_RD_HI_CMD    = 4'd11;
    localparam bridge_state_t S_RD_HI_WAIT   = 4'd12;
    localparam bridge_state_t S_REPLY        = 4'd13;

    function automatic logic is_write(input logic [3:0] msg_type);
        return (msg_type == e_bedrock_mem_uc_wr) || (msg_type == e_bedrock_mem_wr);
    endfunction

    function automatic logic size_ok(input logic [2:0] size);
        return (size == e_bedrock_msg_size_1) || (size == e_bedrock_msg_size_2)
            || (size == e_bedrock_msg_size_4);
    endfunction

    function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] lane);
        logic [3:0] mask;
        case (size)
            e_bedrock_msg_size_1: mask = 4'b0001 << lane;
            e_bedrock_msg_size_2: mask = 4'b0011 << lane;
            default:              mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bp_mc_direct_access_bridge.sv
// Turns one BP uncached load/store to a manycore EPA into the mailbox command
// sequence (credit poll, two request words, entries poll, two response reads).
module bp_mc_direct_access_bridge
    import bp_mc_link_pkg::*;
#(
    parameter int                         mc_x_cord_width_p = 4,
    parameter int                         mc_y_cord_width_p = 4,
    parameter logic [paddr_width_gp-1:0]  link_base_addr_p  = '0,
    parameter int                         poll_limit_p      = 1024
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [cce_mem_msg_width_gp-1:0] io_cmd_i,
    input  logic                            io_cmd_v_i,
    output logic                            io_cmd_ready_o,
    output logic [cce_mem_msg_width_gp-1:0] io_resp_o,
    output logic                            io_resp_v_o,
    input  logic                            io_resp_yumi_i,
    output logic [cce_mem_msg_width_gp-1:0] link_cmd_o,
    output logic                            link_cmd_v_o,
    input  logic                            link_cmd_ready_i,
    input  logic [cce_mem_msg_width_gp-1:0] link_resp_i,
    input  logic                            link_resp_v_i,
    output logic                            link_resp_yumi_o,
    input  logic [mc_x_cord_width_p-1:0]    my_x_i,
    input  logic [mc_y_cord_width_p-1:0]    my_y_i,
    output logic                            error_o
);

    localparam int poll_cnt_w_lp = $clog2(poll_limit_p + 1);
    localparam logic [poll_cnt_w_lp-1:0] poll_last_lp = poll_cnt_w_lp'(poll_limit_p - 1);

    bridge_state_t             state_q, state_d;
    bp_io_msg_s                cmd_q, cmd_d;
    logic [4:0]                tag_q, tag_d;
    logic [4:0]                cur_tag_q, cur_tag_d;
    logic [poll_cnt_w_lp-1:0]  poll_cnt_q, poll_cnt_d;
    logic [63:0]               resp_data_q, resp_data_d;
    logic                      error_q, error_d;

    bp_io_msg_s                io_cmd, link_resp, link_cmd;
    host_request_packet_s      req_pkt;
    host_response_packet_s     rsp_pkt;
    logic                      cmd_is_wr;
    logic [1:0]                lane;
    logic [31:0]               rsp_shift;
    logic [63:0]               load_data;
    logic                      in_wait;

    assign io_cmd    = bp_io_msg_s'(io_cmd_i);
    assign link_resp = bp_io_msg_s'(link_resp_i);
    assign rsp_pkt   = host_response_packet_s'({64'b0, link_resp.data});
    assign cmd_is_wr = is_write(cmd_q.msg_type);
    assign lane      = cmd_q.addr[1:0];

    always_comb begin
        req_pkt         = '0;
        req_pkt.x_dst   = 8'(cmd_q.addr[32 +: mc_x_cord_width_p]);
        req_pkt.y_dst   = 8'(cmd_q.addr[32 + mc_x_cord_width_p +: mc_y_cord_width_p]);
        req_pkt.x_src   = 8'(my_x_i);
        req_pkt.y_src   = 8'(my_y_i);
        if (cmd_is_wr) begin
            req_pkt.op      = e_remote_store;
            req_pkt.addr    = cmd_q.addr[31:0];
            req_pkt.payload = cmd_q.data[31:0] << {lane, 3'b000};
            req_pkt.reg_id  = {4'b0, byte_mask(cmd_q.size, lane)};
        end else begin
            req_pkt.op      = e_remote_load;
            req_pkt.addr    = {cmd_q.addr[31:2], 2'b00};
            req_pkt.reg_id  = {3'b0, cur_tag_q};
        end
    end

    // Returned word is always 32 bits; pick the addressed lane and zero-extend.
    assign rsp_shift = rsp_pkt.data >> {lane, 3'b000};
    always_comb begin
        case (cmd_q.size)
            e_bedrock_msg_size_1: load_data = {56'b0, rsp_shift[7:0]};
            e_bedrock_msg_size_2: load_data = {48'b0, rsp_shift[15:0]};
            default:              load_data = {32'b0, rsp_shift};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        tag_d       = tag_q;
        cur_tag_d   = cur_tag_q;
        poll_cnt_d  = poll_cnt_q;
        resp_data_d = resp_data_q;
        error_d     = error_q;
        case (state_q)
            S_READY: begin
                if (io_cmd_v_i) begin
                    cmd_d       = io_cmd;
                    cur_tag_d   = tag_q;
                    poll_cnt_d  = '0;
                    resp_data_d = '0;
                    if (!size_ok(io_cmd.size)) begin
                        error_d = 1'b1;
                        state_d = S_REPLY;
                    end else begin
                        state_d = S_CRED_CMD;
                        if (!is_write(io_cmd.msg_type)) tag_d = tag_q + 5'd1;
                    end
                end
            end
            S_CRED_CMD:    if (link_cmd_ready_i) state_d = S_CRED_WAIT;
            S_CRED_WAIT: begin
                if (link_resp_v_i) begin
                    if (link_resp.data != '0) begin
                        poll_cnt_d = '0;
                        state_d    = S_SEND_LO_CMD;
                    end else if (poll_cnt_q == poll_last_lp) begin
                        error_d = 1'b1;
                        state_d = S_REPLY;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 1'b1;
                        state_d    = S_CRED_CMD;
                    end
                end
            end
            S_SEND_LO_CMD:  if (link_cmd_ready_i) state_d = S_SEND_LO_WAIT;
            S_SEND_LO_WAIT: if (link_resp_v_i)    state_d = S_SEND_HI_CMD;
            S_SEND_HI_CMD:  if (link_cmd_ready_i) state_d = S_SEND_HI_WAIT;
            S_SEND_HI_WAIT: if (link_resp_v_i)    state_d = cmd_is_wr ? S_REPLY : S_ENT_CMD;
            S_ENT_CMD:      if (link_cmd_ready_i) state_d = S_ENT_WAIT;
            S_ENT_WAIT: begin
                if (link_resp_v_i) begin
                    if (link_resp.data[0]) begin
                        poll_cnt_d = '0;
                        state_d    = S_RD_LO_CMD;
                    end else if (poll_cnt_q == poll_last_lp) begin
                        error_d = 1'b1;
                        state_d = S_REPLY;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 1'b1;
                        state_d    = S_ENT_CMD;
                    end
                end
            end
            S_RD_LO_CMD:    if (link_cmd_ready_i) state_d = S_RD_LO_WAIT;
            S_RD_LO_WAIT: begin
                if (link_resp_v_i) begin
                    resp_data_d = load_data;
                    if (rsp_pkt.reg_id != {3'b0, cur_tag_q}) error_d = 1'b1;
                    state_d = S_RD_HI_CMD;
                end
            end
            S_RD_HI_CMD:    if (link_cmd_ready_i) state_d = S_RD_HI_WAIT;
            S_RD_HI_WAIT:   if (link_resp_v_i)    state_d = S_REPLY;
            S_REPLY:        if (io_resp_yumi_i)   state_d = S_READY;
            default:        state_d = S_READY;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_READY;
            cmd_q       <= '0;
            tag_q       <= '0;
            cur_tag_q   <= '0;
            poll_cnt_q  <= '0;
            resp_data_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            tag_q       <= tag_d;
            cur_tag_q   <= cur_tag_d;
            poll_cnt_q  <= poll_cnt_d;
            resp_data_q <= resp_data_d;
            error_q     <= error_d;
        end
    end

    // Mailbox command is decoded from state only so it never depends on ready.
    always_comb begin
        link_cmd = '0;
        case (state_q)
            S_CRED_CMD: begin
                link_cmd.msg_type = e_bedrock_mem_uc_rd;
                link_cmd.size     = e_bedrock_msg_size_8;
                link_cmd.addr     = link_base_addr_p | mbox_credits_gp;
            end
            S_SEND_LO_CMD, S_SEND_HI_CMD: begin
                link_cmd.msg_type = e_bedrock_mem_uc_wr;
                link_cmd.size     = e_bedrock_msg_size_8;
                link_cmd.addr     = link_base_addr_p | mbox_req_fifo_gp;
                link_cmd.data     = (state_q == S_SEND_LO_CMD) ? req_pkt[63:0] : req_pkt[127:64];
            end
            S_ENT_CMD: begin
                link_cmd.msg_type = e_bedrock_mem_uc_rd;
                link_cmd.size     = e_bedrock_msg_size_8;
                link_cmd.addr     = link_base_addr_p | mbox_resp_entries_gp;
            end
            S_RD_LO_CMD, S_RD_HI_CMD: begin
                link_cmd.msg_type = e_bedrock_mem_uc_rd;
                link_cmd.size     = e_bedrock_msg_size_8;
                link_cmd.addr     = link_base_addr_p | mbox_resp_fifo_gp;
            end
            default: link_cmd = '0;
        endcase
    end

    assign in_wait = (state_q == S_CRED_WAIT) || (state_q == S_SEND_LO_WAIT)
                  || (state_q == S_SEND_HI_WAIT) || (state_q == S_ENT_WAIT)
                  || (state_q == S_RD_LO_WAIT) || (state_q == S_RD_HI_WAIT);

    assign link_cmd_o       = link_cmd;
    assign link_cmd_v_o     = (state_q == S_CRED_CMD) || (state_q == S_SEND_LO_CMD)
                           || (state_q == S_SEND_HI_CMD) || (state_q == S_ENT_CMD)
                           || (state_q == S_RD_LO_CMD) || (state_q == S_RD_HI_CMD);
    assign link_resp_yumi_o = in_wait & link_resp_v_i;
    assign io_cmd_ready_o   = (state_q == S_READY) & ~reset_i;
    assign io_resp_v_o      = (state_q == S_REPLY);
    assign io_resp_o        = (state_q == S_REPLY)
                            ? {resp_data_q, cmd_q.addr, cmd_q.size, cmd_q.msg_type}
                            : '0;
    assign error_o          = error_q;

    logic unused_bits;
    assign unused_bits = ^{cmd_q, link_resp, rsp_pkt};

endmodule
